traffic_phase_timer: RTL and testbench

Parametrised phase timer for the traffic-light controller: sequences through `pNUM_PHASES` light phases in fixed cyclic order. It counts each phase down from a runtime-programmable duration, using a built-in tick prescaler. It replaces the single-phase down-counter: it owns phase sequencing, pause/hold, forced phase jumps and a per-phase duration register file, so the top-level FSM only decodes `phase` to lamps.

---
 rtl/traffic_phase_timer_pkg.sv | 27 ++
 rtl/traffic_phase_timer_if.sv | 32 +++
 rtl/traffic_phase_timer_tick_prescaler.sv | 31 +++
 rtl/traffic_phase_timer.sv | 115 +++++++++++
 tb/tb_traffic_phase_timer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_phase_timer_pkg.sv
// Shared constants for the traffic-light phase timer: phase indices and
// default per-phase durations.
package traffic_pkg;

    localparam int GREEN  = 0;
    localparam int YELLOW = 1;
    localparam int RED    = 2;

    localparam int NUM_PHASES_DEF = 3;
    localparam int CNT_WIDTH_DEF  = 5;
    localparam int IDX_WIDTH_DEF  = 2;

    localparam logic [CNT_WIDTH_DEF-1:0] DUR_GREEN  = 5'd14;
    localparam logic [CNT_WIDTH_DEF-1:0] DUR_YELLOW = 5'd2;
    localparam logic [CNT_WIDTH_DEF-1:0] DUR_RED    = 5'd17;

    // Phase i lives at bits [i*CNT_WIDTH +: CNT_WIDTH].
    localparam logic [NUM_PHASES_DEF*CNT_WIDTH_DEF-1:0] RST_DURS_DEF =
        {DUR_RED, DUR_YELLOW, DUR_GREEN};

    typedef enum logic [IDX_WIDTH_DEF-1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_RED    = 2'd2
    } phase_e;

endpackage

// File: rtl/traffic_phase_timer_if.sv
// Control/status bundle between the lamp controller (master) and the phase
// timer (slave).
interface traffic_phase_timer_if #(
    parameter int pNUM_PHASES = 3,
    parameter int pCNT_WIDTH  = 5,
    parameter int pIDX_WIDTH  = 2
);
    logic                   en;
    logic                   hold;
    logic                   force_valid;
    logic [pIDX_WIDTH-1:0]  force_phase;
    logic                   cfg_we;
    logic [pIDX_WIDTH-1:0]  cfg_idx;
    logic [pCNT_WIDTH-1:0]  cfg_val;

    logic [pNUM_PHASES-1:0] phase;
    logic [pIDX_WIDTH-1:0]  phase_idx;
    logic [pCNT_WIDTH-1:0]  count_out;
    logic                   last;
    logic                   phase_start;

    modport master (
        output en, hold, force_valid, force_phase, cfg_we, cfg_idx, cfg_val,
        input  phase, phase_idx, count_out, last, phase_start
    );

    modport slave (
        input  en, hold, force_valid, force_phase, cfg_we, cfg_idx, cfg_val,
        output phase, phase_idx, count_out, last, phase_start
    );

endinterface

// File: rtl/traffic_phase_timer_tick_prescaler.sv
// Divides the clock into count ticks; the divider position is frozen while
// run is low and restarts from zero on clr.
module tick_prescaler #(
    parameter int pTICK_DIV  = 4,
    parameter int pDIV_WIDTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic tick
);
    localparam logic [pDIV_WIDTH-1:0] LAST_CNT = pDIV_WIDTH'(pTICK_DIV - 1);

    logic [pDIV_WIDTH-1:0] r_div;

    assign tick = run && (r_div == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (clr) begin
            r_div <= '0;
        end else if (tick) begin
            r_div <= '0;
        end else if (run) begin
            r_div <= r_div + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_timer.sv
// Cyclic phase sequencer: counts each phase down from a programmable
// duration, with pause, forced jumps and a per-phase duration register file.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int pNUM_PHASES = NUM_PHASES_DEF,
    parameter int pCNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int pIDX_WIDTH  = IDX_WIDTH_DEF,
    parameter int pTICK_DIV   = 4,
    parameter int pDIV_WIDTH  = 3,
    parameter logic [pNUM_PHASES*pCNT_WIDTH-1:0] pRST_DURS = RST_DURS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    traffic_phase_timer_if.slave bus
);
    localparam logic [pIDX_WIDTH-1:0] LAST_IDX = pIDX_WIDTH'(pNUM_PHASES - 1);

    logic [pCNT_WIDTH-1:0]  r_dur [pNUM_PHASES];
    logic [pIDX_WIDTH-1:0]  r_phase_idx;
    logic [pNUM_PHASES-1:0] r_phase;
    logic [pCNT_WIDTH-1:0]  r_count;
    logic                   r_phase_start;

    logic                   w_run;
    logic                   w_tick;
    logic                   w_force_ok;
    logic                   w_load;
    logic [pIDX_WIDTH-1:0]  w_next_idx;
    logic [pIDX_WIDTH-1:0]  w_load_idx;
    logic [pNUM_PHASES-1:0] w_idx_hit;
    logic [pCNT_WIDTH-1:0]  w_load_dur;
    logic [pCNT_WIDTH-1:0]  w_count_next;

    assign w_run      = bus.en & ~bus.hold;
    assign w_force_ok = bus.force_valid && (int'(bus.force_phase) < pNUM_PHASES);
    assign w_next_idx = (r_phase_idx == LAST_IDX) ? '0 : r_phase_idx + 1'b1;
    assign w_load_idx = w_force_ok ? bus.force_phase : w_next_idx;

    // Force wins over any tick in the same cycle; a tick at zero advances instead of wrapping.
    assign w_load = w_force_ok | (w_tick && (r_count == '0));

    tick_prescaler #(
        .pTICK_DIV  (pTICK_DIV),
        .pDIV_WIDTH (pDIV_WIDTH)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run),
        .clr   (w_force_ok),
        .tick  (w_tick)
    );

    generate
        for (genvar gi = 0; gi < pNUM_PHASES; gi++) begin : g_phase_hit
            assign w_idx_hit[gi] = (w_load_idx == pIDX_WIDTH'(gi));
        end
    endgenerate

    // Reads the pre-write duration, so a same-cycle config write only affects later loads.
    always_comb begin
        w_load_dur = '0;
        for (int i = 0; i < pNUM_PHASES; i++) begin
            if (w_idx_hit[i]) begin
                w_load_dur = r_dur[i];
            end
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_load) begin
            w_count_next = w_load_dur;
        end else if (w_tick) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < pNUM_PHASES; i++) begin
                r_dur[i] <= pRST_DURS[i*pCNT_WIDTH +: pCNT_WIDTH];
            end
        end else begin
            for (int i = 0; i < pNUM_PHASES; i++) begin
                if (bus.cfg_we && (bus.cfg_idx == pIDX_WIDTH'(i))) begin
                    r_dur[i] <= bus.cfg_val;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase_idx   <= '0;
            r_phase       <= pNUM_PHASES'(1);
            r_count       <= pRST_DURS[0 +: pCNT_WIDTH];
            r_phase_start <= 1'b0;
        end else begin
            r_count       <= w_count_next;
            r_phase_start <= w_load;
            if (w_load) begin
                r_phase_idx <= w_load_idx;
                r_phase     <= w_idx_hit;
            end
        end
    end

    assign bus.phase       = r_phase;
    assign bus.phase_idx   = r_phase_idx;
    assign bus.count_out   = r_count;
    assign bus.last        = (r_count == '0);
    assign bus.phase_start = r_phase_start;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench: one divide-by-1 instance driven from a vector table, one
// divide-by-4 instance driven by hand-written multi-cycle sequences.
module tb_traffic_phase_timer;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    traffic_phase_timer_if #(.pNUM_PHASES(3), .pCNT_WIDTH(5), .pIDX_WIDTH(2)) bus1 ();
    traffic_phase_timer_if #(.pNUM_PHASES(3), .pCNT_WIDTH(5), .pIDX_WIDTH(2)) bus4 ();

    traffic_phase_timer #(.pTICK_DIV(1), .pDIV_WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    traffic_phase_timer #(.pTICK_DIV(4), .pDIV_WIDTH(3)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int en, hold, fv, fp, we, ci, cv;
        int n;
        int ei, ec, el, es;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_state(input bit sel4, input string tag,
                               input int ei, input int ec, input int el, input int es);
        int g_idx, g_cnt, g_last, g_st, g_ph;
        if (sel4) begin
            g_idx = int'(bus4.phase_idx); g_cnt = int'(bus4.count_out);
            g_last = int'(bus4.last); g_st = int'(bus4.phase_start); g_ph = int'(bus4.phase);
        end else begin
            g_idx = int'(bus1.phase_idx); g_cnt = int'(bus1.count_out);
            g_last = int'(bus1.last); g_st = int'(bus1.phase_start); g_ph = int'(bus1.phase);
        end
        $display("%s: idx=%0d cnt=%0d last=%0d start=%0d phase=%0d", tag, g_idx, g_cnt, g_last, g_st, g_ph);
        chk({tag, ".idx"},   g_idx,  ei);
        chk({tag, ".count"}, g_cnt,  ec);
        chk({tag, ".last"},  g_last, el);
        chk({tag, ".start"}, g_st,   es);
        chk({tag, ".phase"}, g_ph,   1 << ei);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input bit sel4, input int en, input int hold, input int fv, input int fp,
                         input int we, input int ci, input int cv);
        if (sel4) begin
            bus4.en = 1'(en); bus4.hold = 1'(hold); bus4.force_valid = 1'(fv);
            bus4.force_phase = 2'(fp); bus4.cfg_we = 1'(we); bus4.cfg_idx = 2'(ci);
            bus4.cfg_val = 5'(cv);
        end else begin
            bus1.en = 1'(en); bus1.hold = 1'(hold); bus1.force_valid = 1'(fv);
            bus1.force_phase = 2'(fp); bus1.cfg_we = 1'(we); bus1.cfg_idx = 2'(ci);
            bus1.cfg_val = 5'(cv);
        end
    endtask

    // Bounded wait on the divide-by-4 instance; first match lands just after a tick.
    task automatic wait_for4(input string tag, input int ei, input int ec, input int bound);
        int k;
        bit hit;
        k = 0;
        hit = (int'(bus4.phase_idx) == ei) && (int'(bus4.count_out) == ec);
        while (!hit && k < bound) begin
            step(1);
            k++;
            hit = (int'(bus4.phase_idx) == ei) && (int'(bus4.count_out) == ec);
        end
        $display("%s: reached=%0d after %0d cycles", tag, hit, k);
        chk({tag, ".reached"}, int'(hit), 1);
    endtask

    initial begin
        // en hold fv fp we ci cv | n | idx cnt last start
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0,  1,  0, 13, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 0, 0, 0, 13,  0,  0, 1, 0};
        vecs[2]  = '{1, 0, 0, 0, 0, 0, 0,  1,  1,  2, 0, 1};
        vecs[3]  = '{1, 0, 0, 0, 0, 0, 0,  1,  1,  1, 0, 0};
        vecs[4]  = '{1, 0, 0, 0, 0, 0, 0,  1,  1,  0, 1, 0};
        vecs[5]  = '{1, 0, 0, 0, 0, 0, 0,  1,  2, 17, 0, 1};
        vecs[6]  = '{1, 0, 0, 0, 0, 0, 0, 17,  2,  0, 1, 0};
        vecs[7]  = '{1, 0, 0, 0, 0, 0, 0,  1,  0, 14, 0, 1};
        vecs[8]  = '{1, 1, 0, 0, 0, 0, 0,  3,  0, 14, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 0,  2,  0, 14, 0, 0};
        vecs[10] = '{1, 1, 1, 2, 0, 0, 0,  1,  2, 17, 0, 1};
        vecs[11] = '{1, 1, 1, 3, 0, 0, 0,  1,  2, 17, 0, 0};
        vecs[12] = '{0, 0, 0, 0, 1, 0, 3,  1,  2, 17, 0, 0};
        vecs[13] = '{0, 0, 1, 0, 0, 0, 0,  1,  0,  3, 0, 1};
        vecs[14] = '{1, 0, 0, 0, 1, 3, 9,  1,  0,  2, 0, 0};
        vecs[15] = '{1, 0, 1, 1, 0, 0, 0,  1,  1,  2, 0, 1};
        vecs[16] = '{1, 0, 0, 0, 1, 2, 0,  1,  1,  1, 0, 0};
        vecs[17] = '{1, 0, 0, 0, 0, 0, 0,  2,  2,  0, 1, 1};
        vecs[18] = '{1, 0, 0, 0, 0, 0, 0,  1,  0,  3, 0, 1};
        vecs[19] = '{0, 0, 1, 2, 1, 2, 7,  1,  2,  0, 1, 1};
        vecs[20] = '{0, 0, 1, 2, 0, 0, 0,  1,  2,  7, 0, 1};
        vecs[21] = '{0, 0, 0, 0, 0, 0, 0,  1,  2,  7, 0, 0};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step(3);
        check_state(0, "reset.div1", 0, 14, 0, 0);
        check_state(1, "reset.div4", 0, 14, 0, 0);
        rst_n = 1'b1;

        // Divide-by-1 instance: table of {inputs, cycles, expected outputs}.
        for (int i = 0; i < 22; i++) begin
            drive(0, vecs[i].en, vecs[i].hold, vecs[i].fv, vecs[i].fp,
                  vecs[i].we, vecs[i].ci, vecs[i].cv);
            step(1);
            drive(0, vecs[i].en, vecs[i].hold, 0, vecs[i].fp, 0, vecs[i].ci, vecs[i].cv);
            if (vecs[i].n > 1) step(vecs[i].n - 1);
            check_state(0, $sformatf("vec%0d", i), vecs[i].ei, vecs[i].ec, vecs[i].el, vecs[i].es);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Divide-by-4: green lasts (14+1)*4 = 60 clocks.
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step(3);
        check_state(1, "div4.c3", 0, 14, 0, 0);
        step(1);
        check_state(1, "div4.c4", 0, 13, 0, 0);
        step(55);
        check_state(1, "div4.c59", 0, 0, 1, 0);
        step(1);
        check_state(1, "div4.c60", 1, 2, 0, 1);

        // Hold at count 7 with the prescaler parked at 2.
        wait_for4("hold.wait", 2, 7, 200);
        step(2);
        check_state(1, "hold.pre", 2, 7, 0, 0);
        drive(1, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check_state(1, $sformatf("hold.c%0d", i), 2, 7, 0, 0);
        end
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step(1);
        check_state(1, "hold.rel1", 2, 7, 0, 0);
        step(1);
        check_state(1, "hold.rel2", 2, 6, 0, 0);

        // Force while held; prescaler must restart from zero.
        drive(1, 1, 1, 1, 2, 0, 0, 0);
        step(1);
        check_state(1, "force.held", 2, 17, 0, 1);
        drive(1, 1, 1, 0, 0, 0, 0, 0);
        step(1);
        check_state(1, "force.held2", 2, 17, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step(3);
        check_state(1, "force.run3", 2, 17, 0, 0);
        step(1);
        check_state(1, "force.run4", 2, 16, 0, 0);

        // Force in the same cycle as a tick: the tick is discarded.
        step(3);
        drive(1, 1, 0, 1, 0, 0, 0, 0);
        step(1);
        check_state(1, "force.tick", 0, 14, 0, 1);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step(3);
        check_state(1, "force.tick3", 0, 14, 0, 0);
        step(1);
        check_state(1, "force.tick4", 0, 13, 0, 0);

        // Write dur[1]=5 during phase 1 at count 1: current phase keeps old timing.
        wait_for4("cfg.wait", 1, 1, 200);
        drive(1, 1, 0, 0, 0, 1, 1, 5);
        step(1);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step(6);
        check_state(1, "cfg.c7", 1, 0, 1, 0);
        step(1);
        check_state(1, "cfg.c8", 2, 17, 0, 1);
        drive(1, 1, 0, 1, 1, 0, 0, 0);
        step(1);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        check_state(1, "cfg.reentry", 1, 5, 0, 1);

        // Asynchronous reset mid-red, between clock edges.
        wait_for4("rst.wait", 2, 9, 200);
        #2;
        rst_n = 1'b0;
        #1;
        check_state(1, "rst.async", 0, 14, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 1, 0, 1, 1, 0, 0, 0);
        step(1);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        check_state(1, "rst.dur1", 1, 2, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
